complex_mixer_pipe: RTL and testbench

Parametrised, pipelined complex multiplier for the IF-conversion path. Computes RF × LO (or RF × conj(LO)) per sample under a valid/ready handshake with clock-enable support. Output is rescaled by a static right shift and saturated to the output width, with a sticky overflow flag. Sits between the sample source / NCO and the downstream decimation filters, replacing the fixed 5-bit single-register mixer.

---
 rtl/mixer_pkg.sv | 19 +
 rtl/complex_mixer_pipe_sat_round.sv | 47 ++++
 rtl/complex_mixer_pipe.sv | 126 ++++++++++++
 tb/tb_complex_mixer_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared widths, saturation bounds and conj-mode encoding for the IF mixer.
package mixer_pkg;

   localparam logic CONJ_OFF = 1'b0;
   localparam logic CONJ_ON  = 1'b1;

   function automatic int full_width(input int in_w, input int lo_w);
      return in_w + lo_w + 1;
   endfunction

   function automatic longint sat_max(input int out_w);
      return (longint'(1) <<< (out_w - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int out_w);
      return -(longint'(1) <<< (out_w - 1));
   endfunction

endpackage

// File: rtl/complex_mixer_pipe_sat_round.sv
// Combinational rescale (arithmetic right shift, round-half-up when
// COMPLEX_MIXER_ROUND_EN is defined, else floor) and saturation to OUT_W.
module sat_round
   import mixer_pkg::*;
#(
   parameter int P     = 11,
   parameter int SHIFT = 0,
   parameter int OUT_W = 10
) (
   input  logic signed [P-1:0]     x_i,
   output logic signed [OUT_W-1:0] y_o,
   output logic                    sat_o
);

   // One guard bit for the rounding add, and wide enough to hold both bounds.
   localparam int EW = ((P + 1 > OUT_W) ? P + 1 : OUT_W) + 1;

   localparam logic signed [EW-1:0] MAXV = EW'(sat_max(OUT_W));
   localparam logic signed [EW-1:0] MINV = EW'(sat_min(OUT_W));

`ifdef COMPLEX_MIXER_ROUND_EN
   localparam logic signed [EW-1:0] BIAS =
      (SHIFT > 0) ? EW'(longint'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
`else
   localparam logic signed [EW-1:0] BIAS = '0;
`endif

   logic signed [EW-1:0] ext;
   logic signed [EW-1:0] sum;
   logic signed [EW-1:0] shifted;

   always_comb begin
      ext     = {{(EW - P){x_i[P-1]}}, x_i};
      sum     = ext + BIAS;
      shifted = sum >>> SHIFT;
      sat_o   = 1'b0;
      y_o     = shifted[OUT_W-1:0];
      if (shifted > MAXV) begin
         y_o   = MAXV[OUT_W-1:0];
         sat_o = 1'b1;
      end else if (shifted < MINV) begin
         y_o   = MINV[OUT_W-1:0];
         sat_o = 1'b1;
      end
   end

endmodule

// File: rtl/complex_mixer_pipe.sv
// Two-stage complex mixer RF x LO / RF x conj(LO) with valid/ready, clk_en,
// static shift + saturation and sticky ovf. Rounding: COMPLEX_MIXER_ROUND_EN.
module complex_mixer_pipe
   import mixer_pkg::*;
#(
   parameter int IN_W  = 5,
   parameter int LO_W  = 5,
   parameter int OUT_W = 10,
   parameter int SHIFT = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    clk_en,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  rf_i,
   input  logic signed [IN_W-1:0]  rf_q,
   input  logic signed [LO_W-1:0]  lo_i,
   input  logic signed [LO_W-1:0]  lo_q,
   input  logic                    conj,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] if_i,
   output logic signed [OUT_W-1:0] if_q,
   output logic                    ovf,
   input  logic                    ovf_clear
);

   localparam int P  = full_width(IN_W, LO_W);
   localparam int PW = IN_W + LO_W;

   logic signed [PW-1:0] p_ii_q, p_qq_q, p_iq_q, p_qi_q;
   logic signed [PW-1:0] p_ii_d, p_qq_d, p_iq_d, p_qi_d;
   logic                 conj_q;
   logic                 s1_valid_q;
   logic                 out_valid_q;
   logic signed [OUT_W-1:0] if_i_q, if_q_q;
   logic                 ovf_q, ovf_d;

   logic s1_load, s2_load;
   logic signed [P-1:0] sum_i, sum_q;
   logic signed [OUT_W-1:0] sat_i_val, sat_q_val;
   logic sat_i, sat_q;

   assign s2_load  = clk_en & (~out_valid_q | out_ready);
   assign s1_load  = clk_en & (~s1_valid_q | s2_load);
   assign in_ready = s1_load & ~reset;

   always_comb begin
      p_ii_d = PW'(rf_i) * PW'(lo_i);
      p_qq_d = PW'(rf_q) * PW'(lo_q);
      p_iq_d = PW'(rf_i) * PW'(lo_q);
      p_qi_d = PW'(rf_q) * PW'(lo_i);
   end

   always_comb begin
      if (conj_q == CONJ_ON) begin
         sum_i = P'(p_ii_q) + P'(p_qq_q);
         sum_q = P'(p_qi_q) - P'(p_iq_q);
      end else begin
         sum_i = P'(p_ii_q) - P'(p_qq_q);
         sum_q = P'(p_iq_q) + P'(p_qi_q);
      end
   end

   sat_round #(.P(P), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_sat_i (
      .x_i   (sum_i),
      .y_o   (sat_i_val),
      .sat_o (sat_i)
   );

   sat_round #(.P(P), .SHIFT(SHIFT), .OUT_W(OUT_W)) u_sat_q (
      .x_i   (sum_q),
      .y_o   (sat_q_val),
      .sat_o (sat_q)
   );

   // A saturating transfer beats a coincident clear.
   always_comb begin
      ovf_d = ovf_q;
      if (s2_load && s1_valid_q && (sat_i || sat_q))
         ovf_d = 1'b1;
      else if (ovf_clear)
         ovf_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         if_i_q      <= '0;
         if_q_q      <= '0;
         p_ii_q      <= '0;
         p_qq_q      <= '0;
         p_iq_q      <= '0;
         p_qi_q      <= '0;
         conj_q      <= CONJ_OFF;
      end else if (clk_en) begin
         if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
               p_ii_q <= p_ii_d;
               p_qq_q <= p_qq_d;
               p_iq_q <= p_iq_d;
               p_qi_q <= p_qi_d;
               conj_q <= conj;
            end
         end
         if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               if_i_q <= sat_i_val;
               if_q_q <= sat_q_val;
            end
         end
         ovf_q <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign if_i      = if_i_q;
   assign if_q      = if_q_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_complex_mixer_pipe.sv
// Scoreboard bench for complex_mixer_pipe: directed vectors, decoupled monitor.
module tb_complex_mixer_pipe;

   logic clock = 1'b0;
   logic reset, clk_en, in_valid, conj, out_ready, ovf_clear;
   logic signed [4:0] rf_i, rf_q, lo_i, lo_q;
   logic in_ready, out_valid, ovf;
   logic signed [9:0] if_i, if_q;

   // SHIFT=2 instance for the rescale/rounding vectors
   logic in_valid2, out_ready2, clk_en2, ovf_clear2, conj2;
   logic signed [4:0] rf_i2, rf_q2, lo_i2, lo_q2;
   logic in_ready2, out_valid2, ovf2;
   logic signed [9:0] if_i2, if_q2;

   typedef struct packed {logic signed [9:0] i; logic signed [9:0] q;} exp_t;
   exp_t exp_q[$];
   exp_t mon_e;
   int total = 0;
   int bad = 0;

   int tv[6][4] = '{'{1,0,1,0}, '{2,1,3,0}, '{-1,2,2,2}, '{5,-3,-2,1}, '{7,7,7,-7}, '{-8,4,3,-5}};
   int e0[6][2] = '{'{1,0}, '{6,3}, '{-6,2}, '{-7,11}, '{98,0}, '{-4,52}};
   int e1[6][2] = '{'{1,0}, '{6,3}, '{2,6}, '{-13,1}, '{0,98}, '{-44,-28}};

   always #5 clock = ~clock;

   complex_mixer_pipe dut (
      .clock(clock), .reset(reset), .clk_en(clk_en), .in_valid(in_valid), .in_ready(in_ready),
      .rf_i(rf_i), .rf_q(rf_q), .lo_i(lo_i), .lo_q(lo_q), .conj(conj),
      .out_valid(out_valid), .out_ready(out_ready), .if_i(if_i), .if_q(if_q),
      .ovf(ovf), .ovf_clear(ovf_clear)
   );

   complex_mixer_pipe #(.SHIFT(2)) dut2 (
      .clock(clock), .reset(reset), .clk_en(clk_en2), .in_valid(in_valid2), .in_ready(in_ready2),
      .rf_i(rf_i2), .rf_q(rf_q2), .lo_i(lo_i2), .lo_q(lo_q2), .conj(conj2),
      .out_valid(out_valid2), .out_ready(out_ready2), .if_i(if_i2), .if_q(if_q2),
      .ovf(ovf2), .ovf_clear(ovf_clear2)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && clk_en && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_output: got (%0d,%0d) expected nothing", if_i, if_q);
         end else begin
            mon_e = exp_q.pop_front();
            chk("if_i", if_i, mon_e.i);
            chk("if_q", if_q, mon_e.q);
         end
      end
   end

   task automatic send_one(input int ri, input int rq, input int li, input int lq,
                           input bit cj, input int ei, input int eq);
      int n = 0;
      rf_i = 5'(ri); rf_q = 5'(rq); lo_i = 5'(li); lo_q = 5'(lq); conj = cj;
      in_valid = 1'b1;
      @(negedge clock);
      while (!in_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got in_ready=0 expected 1");
      end else begin
         exp_q.push_back('{10'(ei), 10'(eq)});
      end
      @(posedge clock); #1;
   endtask

   task automatic drain();
      int n = 0;
      in_valid = 1'b0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
      @(posedge clock); #1;
   endtask

   task automatic stream(input bit cj);
      for (int k = 0; k < 6; k++)
         send_one(tv[k][0], tv[k][1], tv[k][2], tv[k][3], cj,
                  cj ? e1[k][0] : e0[k][0], cj ? e1[k][1] : e0[k][1]);
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic snap_v;
      logic signed [9:0] snap_i, snap_q;
      reset = 1; clk_en = 1; in_valid = 0; conj = 0; out_ready = 1; ovf_clear = 0;
      rf_i = 0; rf_q = 0; lo_i = 0; lo_q = 0;
      clk_en2 = 1; in_valid2 = 1; out_ready2 = 1; ovf_clear2 = 0; conj2 = 0;
      rf_i2 = 0; rf_q2 = 0; lo_i2 = 0; lo_q2 = 0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_if_i", if_i, 0);
      chk("rst_if_q", if_q, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 0);
      @(posedge clock); #1 reset = 0;

      // basic products, both conj modes
      send_one(3, -2, 4, 5, 0, 22, 7);
      send_one(3, -2, 4, 5, 1, 2, -23);
      drain();
      chk("ovf_clean", ovf, 0);

      // saturation, stickiness, clear, set-beats-clear
      send_one(-16, -16, -16, -16, 0, 0, 511);
      drain();
      chk("ovf_set", ovf, 1);
      repeat (2) @(negedge clock);
      chk("ovf_sticky", ovf, 1);
      @(posedge clock); #1 ovf_clear = 1;
      @(posedge clock); #1 ovf_clear = 0;
      @(negedge clock);
      chk("ovf_cleared", ovf, 0);
      @(posedge clock); #1;
      rf_i = -16; rf_q = -16; lo_i = -16; lo_q = -16; conj = 0; in_valid = 1;
      @(negedge clock);
      chk("coinc_in_ready", in_ready, 1);
      exp_q.push_back('{10'sd0, 10'sd511});
      @(posedge clock); #1 in_valid = 0; ovf_clear = 1;
      @(posedge clock); #1 ovf_clear = 0;
      @(negedge clock);
      chk("ovf_set_wins", ovf, 1);
      drain();

      // back-pressure: out_ready low for cycles 3..7
      fork
         stream(0);
         begin
            repeat (3) @(posedge clock);
            #1 out_ready = 0;
            repeat (4) @(negedge clock);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            @(posedge clock); #1 out_ready = 1;
         end
      join
      drain();

      // clock enable freeze mid-stream
      fork
         stream(1);
         begin
            repeat (3) @(posedge clock);
            #1 clk_en = 0;
            @(negedge clock);
            snap_v = out_valid; snap_i = if_i; snap_q = if_q;
            chk("freeze_in_ready0", in_ready, 0);
            repeat (2) begin
               @(posedge clock);
               @(negedge clock);
               chk("freeze_out_valid", out_valid, snap_v);
               chk("freeze_if_i", if_i, snap_i);
               chk("freeze_if_q", if_q, snap_q);
               chk("freeze_in_ready", in_ready, 0);
            end
            @(posedge clock); #1 clk_en = 1;
         end
      join
      drain();

      // reset with two samples in flight (ovf is set beforehand)
      send_one(-16, -16, -16, -16, 0, 0, 511);
      send_one(2, 1, 3, 0, 0, 6, 3);
      in_valid = 0;
      reset = 1;
      exp_q.delete();
      @(posedge clock); #1 reset = 0;
      @(negedge clock);
      chk("post_rst_out_valid", out_valid, 0);
      chk("post_rst_if_i", if_i, 0);
      chk("post_rst_if_q", if_q, 0);
      chk("post_rst_ovf", ovf, 0);
      repeat (2) @(negedge clock);
      chk("post_rst_idle", out_valid, 0);
      @(posedge clock); #1;
      rf_i = 3; rf_q = -2; lo_i = 4; lo_q = 5; conj = 0; in_valid = 1;
      @(negedge clock);
      chk("lat_in_ready", in_ready, 1);
      exp_q.push_back('{10'sd22, 10'sd7});
      @(posedge clock); #1 in_valid = 0;
      @(negedge clock);
      chk("lat_edge1", out_valid, 0);
      @(negedge clock);
      chk("lat_edge2", out_valid, 1);
      drain();

      // SHIFT=2 rescale
      rf_i2 = 3; lo_i2 = 2;
      repeat (3) @(posedge clock);
      @(negedge clock);
`ifdef COMPLEX_MIXER_ROUND_EN
      chk("shift_pos", if_i2, 2);
`else
      chk("shift_pos", if_i2, 1);
`endif
      chk("shift_pos_q", if_q2, 0);
      @(posedge clock); #1 rf_i2 = -3;
      repeat (3) @(posedge clock);
      @(negedge clock);
`ifdef COMPLEX_MIXER_ROUND_EN
      chk("shift_neg", if_i2, -1);
`else
      chk("shift_neg", if_i2, -2);
`endif
      chk("shift_ovf", ovf2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
